// File: rtl/fifo_pkg.sv
// Shared constants, pointer-width helper and status bundle for the FIFO and its checkers.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int FIFO_DWIDTH_DEF = 8;

  // Pointer width: address bits plus one wrap bit.
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic over_flow;
    logic under_flow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one registered read port.
module fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-address write on this edge is not visible here: the old word is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_core.sv
// Single-clock FIFO with active-low strobes, occupancy count, almost thresholds and sticky error flags.
module fifo_core
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = FIFO_DWIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_n,
  input  logic                     rd_n,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     err_clr,
  output logic [DWIDTH-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     over_flow,
  output logic                     under_flow
);

  localparam int PW = clog2p1(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE    = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cnt;
  logic          ovf;
  logic          unf;
  logic          rd_acc;
  logic          wr_acc;
  logic          ovf_set;
  logic          unf_set;
  fifo_status_t  status;

  assign status.full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign status.empty        = (wr_ptr == rd_ptr);
  assign status.almost_full  = (cnt >= AF_THR);
  assign status.almost_empty = (cnt <= AE_THR);
  assign status.over_flow    = ovf;
  assign status.under_flow   = unf;

  // A pop frees a slot on the same edge, so a full FIFO still takes a write when read.
  assign rd_acc  = !rd_n && !status.empty;
  assign wr_acc  = !wr_n && (!status.full || rd_acc);
  assign ovf_set = !wr_n && status.full && !rd_acc;
  assign unf_set = !rd_n && status.empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
      dout_valid <= rd_acc;
      // A new error on the clearing cycle takes priority over the clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (unf_set) begin
        unf <= 1'b1;
      end else if (err_clr) begin
        unf <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

  assign count        = cnt;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign over_flow    = status.over_flow;
  assign under_flow   = status.under_flow;

endmodule

// File: tb/tb_fifo_core.sv
// Bench for fifo_core: directed scenarios plus randomized traffic against a queue-based reference.
module tb_fifo_core;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_n;
  logic          rd_n;
  logic [DW-1:0] din;
  logic          err_clr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          over_flow;
  logic          under_flow;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of stored words plus the visible output state.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  fifo_core #(
    .DWIDTH   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_n         (wr_n),
    .rd_n         (rd_n),
    .din          (din),
    .err_clr      (err_clr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .over_flow    (over_flow),
    .under_flow   (under_flow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Drive one clock of stimulus, advance the model, return #1 after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
    int   sz;
    logic racc, wacc, oset, uset;
    wr_n    = w;
    rd_n    = r;
    din     = d;
    err_clr = c;
    sz   = mq.size();
    racc = !r && (sz > 0);
    wacc = !w && ((sz < DEPTH) || racc);
    oset = !w && (sz == DEPTH) && !racc;
    uset = !r && (sz == 0);
    m_valid = racc;
    if (racc) m_dout = mq.pop_front();
    if (wacc) mq.push_back(d);
    if (oset) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (uset) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    @(posedge clk);
    #1;
    wr_n    = 1'b1;
    rd_n    = 1'b1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; din = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || dout !== '0 || dout_valid !== 1'b0 ||
        over_flow !== 1'b0 || under_flow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b dout=%h dv=%b ovf=%b unf=%b, required 0 1 0 1 0 00 0 0 0",
               count, empty, full, almost_empty, almost_full, dout, dout_valid, over_flow, under_flow);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, DW'(8'h30 + i), 1'b0);
    cycle(1'b0, 1'b0, 8'h35, 1'b0);
    tests++;
    if (count !== CW'(5) || dout_valid !== 1'b1 || dout !== 8'h30) begin
      fails++;
      $display("FAIL pre_reset: count=%0d dv=%b dout=%h, required 5 1 30", count, dout_valid, dout);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || over_flow !== 1'b0 ||
        under_flow !== 1'b0 || dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d empty=%b full=%b ovf=%b unf=%b dv=%b, required 0 1 0 0 0 0",
               count, empty, full, over_flow, under_flow, dout_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, DW'(i), 1'b0);
      tests++;
      if (count !== CW'(i + 1) || almost_full !== ((i + 1) >= AF) ||
          almost_empty !== ((i + 1) <= AE)) begin
        fails++;
        $display("FAIL fill_%0d: count=%0d af=%b ae=%b, required %0d %b %b",
                 i, count, almost_full, almost_empty, i + 1, (i + 1) >= AF, (i + 1) <= AE);
      end
    end
    tests++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: full=%b empty=%b, required 1 0", full, empty);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    tests++;
    if (over_flow !== 1'b1 || count !== CW'(DEPTH) || full !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: ovf=%b count=%0d full=%b, required 1 16 1", over_flow, count, full);
    end
    repeat (3) cycle(1'b1, 1'b1, 8'h00, 1'b0);
    tests++;
    if (over_flow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: ovf=%b, required 1", over_flow);
    end
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
    tests++;
    if (over_flow !== 1'b0 || count !== CW'(DEPTH)) begin
      fails++;
      $display("FAIL overflow_clear: ovf=%b count=%0d, required 0 16", over_flow, count);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      tests++;
      if (dout !== DW'(i) || dout_valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_%0d: dout=%h dv=%b, required %h 1", i, dout, dout_valid, DW'(i));
      end
    end
    cycle(1'b1, 1'b1, 8'h00, 1'b0);
    tests++;
    if (empty !== 1'b1 || count !== '0 || dout_valid !== 1'b0 || under_flow !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: empty=%b count=%0d dv=%b unf=%b, required 1 0 0 0",
               empty, count, dout_valid, under_flow);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    tests++;
    if (under_flow !== 1'b1 || dout !== 8'h0F || dout_valid !== 1'b0 || over_flow !== 1'b0) begin
      fails++;
      $display("FAIL underflow: unf=%b dout=%h dv=%b ovf=%b, required 1 0f 0 0",
               under_flow, dout, dout_valid, over_flow);
    end
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
    tests++;
    if (under_flow !== 1'b0) begin
      fails++;
      $display("FAIL underflow_clear: unf=%b, required 0", under_flow);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, DW'(8'h10 + i), 1'b0);
    cycle(1'b0, 1'b0, 8'h55, 1'b0);
    tests++;
    if (count !== CW'(DEPTH) || full !== 1'b1 || over_flow !== 1'b0 ||
        dout !== 8'h10 || dout_valid !== 1'b1) begin
      fails++;
      $display("FAIL simul_full: count=%0d full=%b ovf=%b dout=%h dv=%b, required 16 1 0 10 1",
               count, full, over_flow, dout, dout_valid);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      tests++;
      if (dout !== ((i < DEPTH) ? DW'(8'h10 + i) : 8'h55)) begin
        fails++;
        $display("FAIL simul_drain_%0d: dout=%h, required %h",
                 i, dout, (i < DEPTH) ? DW'(8'h10 + i) : 8'h55);
      end
    end
    cycle(1'b0, 1'b0, 8'h66, 1'b0);
    tests++;
    if (count !== CW'(1) || under_flow !== 1'b1 || dout_valid !== 1'b0 || empty !== 1'b0) begin
      fails++;
      $display("FAIL simul_empty: count=%0d unf=%b dv=%b empty=%b, required 1 1 0 0",
               count, under_flow, dout_valid, empty);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    tests++;
    if (dout !== 8'h66 || dout_valid !== 1'b1 || empty !== 1'b1) begin
      fails++;
      $display("FAIL simul_readback: dout=%h dv=%b empty=%b, required 66 1 1", dout, dout_valid, empty);
    end
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_wrap();
    int wv = 0;
    int rv = 0;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 5; k++) begin
        if (b % 2 == 0) begin
          cycle(1'b0, 1'b1, DW'(8'hC0 + wv), 1'b0);
          wv++;
        end else begin
          cycle(1'b1, 1'b0, 8'h00, 1'b0);
          tests++;
          if (dout !== DW'(8'hC0 + rv) || dout_valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap_data_%0d: dout=%h dv=%b, required %h 1", rv, dout, dout_valid, DW'(8'hC0 + rv));
          end
          rv++;
        end
        tests++;
        if (count > CW'(5) || over_flow !== 1'b0 || under_flow !== 1'b0) begin
          fails++;
          $display("FAIL wrap_state_%0d_%0d: count=%0d ovf=%b unf=%b, required <=5 0 0",
                   b, k, count, over_flow, under_flow);
        end
      end
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
      r = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
      c = ($urandom_range(0, 99) < 5);
      if (n >= 200) begin
        w = ($urandom_range(0, 99) < 40) ? 1'b0 : 1'b1;
        r = ($urandom_range(0, 99) < 60) ? 1'b0 : 1'b1;
      end
      cycle(w, r, DW'($urandom), c);
      tests++;
      if (count !== CW'(mq.size()) || dout_valid !== m_valid || dout !== m_dout ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
          almost_full !== (mq.size() >= AF) || almost_empty !== (mq.size() <= AE) ||
          over_flow !== m_ovf || under_flow !== m_unf) begin
        fails++;
        $display("FAIL random_%0d: count=%0d dv=%b dout=%h ovf=%b unf=%b, required %0d %b %h %b %b",
                 n, count, dout_valid, dout, over_flow, under_flow,
                 mq.size(), m_valid, m_dout, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_core.md
Name: fifo_core

Overview:
- Synchronous single-clock FIFO with active-low read/write strobes.
- Generates the over_flow and under_flow error flags that the FIFO protocol checkers monitor.
- Sits between a producer that drives wr_n/din and a consumer that drives rd_n and takes dout.
- Provides full/empty, programmable almost thresholds, an occupancy count and sticky error flags.

Parameters:
- DWIDTH, 8: data width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk, input, 1: the single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- wr_n, input, 1: write strobe, active low. One push per cycle while low.
- rd_n, input, 1: read strobe, active low. One pop per cycle while low.
- din, input, DWIDTH: write data, sampled on the clk edge where wr_n=0.
- err_clr, input, 1: synchronous clear of over_flow and under_flow, active high.
- dout, output, DWIDTH: read data, registered.
- dout_valid, output, 1: dout holds newly popped data this cycle.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- over_flow, output, 1: sticky flag; a write was attempted while full.
- under_flow, output, 1: sticky flag; a read was attempted while empty.

Behaviour:
- Reset (async assert, sync release):
  - Pointers = 0, count = 0, dout = 0, dout_valid = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - over_flow = 0, under_flow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Pointers: wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits. The extra MSB is the wrap bit.
  - full when the addresses are equal and the wrap bits differ.
  - empty when the pointers are equal.
  - Pointers increment modulo 2*DEPTH.
- Write accepted (wr_acc) when wr_n=0 and (!full or rd_acc).
  - mem[wr_ptr] <= din; wr_ptr increments.
- Read accepted (rd_acc) when rd_n=0 and !empty.
  - dout <= mem[rd_ptr] on that edge; rd_ptr increments.
  - dout_valid = 1 for the next cycle only.
  - Read latency is 1 cycle. No write-to-read bypass.
- Count update:
  - count += 1 on wr_acc only.
  - count -= 1 on rd_acc only.
  - count unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When full: both accepted; count stays DEPTH; no over_flow.
  - When empty: write accepted, read rejected; count becomes 1; under_flow sets.
  - Otherwise: both accepted.
- Flags:
  - full, empty, almost_full and almost_empty are derived combinationally from the registered pointers/count.
  - They reflect state after the last edge.
- Error flags:
  - over_flow sets on the edge where wr_n=0, full=1 and rd_acc=0. The write is dropped; contents and pointers are unchanged.
  - under_flow sets on the edge where rd_n=0 and empty=1. dout holds its value; dout_valid = 0.
  - Both flags are sticky until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- dout holds its last value when no read is accepted.

Decomposition:
- fifo_pkg holds:
  - constants FIFO_DEPTH_DEF=16 and FIFO_DWIDTH_DEF=8;
  - a ptr-width function clog2p1(depth);
  - typedef fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, over_flow, under_flow} for use by checkers and the top level.
- One sub-module, fifo_mem:
  - simple dual-port register array;
  - one synchronous write port (we, waddr, wdata);
  - one synchronous read port (re, raddr, rdata), producing the registered dout.
- fifo_core holds pointers, count, flag and error logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream with count=5 -> same cycle count=0, empty=1, full=0, over_flow=0, under_flow=0, dout_valid=0.
- Fill: 16 cycles of wr_n=0 with din=0x00..0x0F -> full=1 and count=16 after the 16th edge; almost_full first high at count=14.
- Overflow: from full, one extra write (wr_n=0, rd_n=1, din=0xAA) -> over_flow=1 next cycle and stays high; count=16. A subsequent drain returns 0x00..0x0F with no 0xAA. err_clr=1 -> over_flow=0.
- Drain and underflow: 16 reads -> dout = 0x00..0x0F, each one cycle after its rd_n=0 edge; empty=1. A 17th read -> under_flow=1; dout stays 0x0F; dout_valid=0.
- Simultaneous operations:
  - Full plus wr_n=0/rd_n=0 -> count stays 16, no over_flow, popped data = oldest entry.
  - Empty plus both strobes -> count=1, under_flow=1, the written word is read back next.
- Wrap-around: 40 cycles of alternating push/pop bursts of 5 -> data order preserved across the pointer wrap; count never exceeds 5; no error flags.
